dbg_view_sel: RTL and testbench

- Parametrised, registered debug-display selector for the CPU statistics/monitor path.
- Picks one of NUM_CH statistic words (PC, cycle count, jump count, branch counts, memory data, load-use stalls, syscall output, ...) for the board display.
- Adds to plain switch selection: auto-scan through channels with a programmable dwell, a freeze/hold mode, and a "displayed channel" index output for the display digits.
- Sits between the CPU counters and the display driver.

---
 rtl/dbg_view_pkg.sv | 33 +++
 rtl/dbg_scan_timer.sv | 69 ++++++
 rtl/dbg_view_sel.sv | 115 +++++++++++
 tb/tb_dbg_view_sel.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/dbg_view_pkg.sv
// Shared definitions for the debug-display selector: mode encodings, FSM state type
// and the default channel assignment of the CPU statistics words.
package dbg_view_pkg;

  localparam logic [1:0] MODE_MANUAL = 2'b00;
  localparam logic [1:0] MODE_SCAN   = 2'b01;
  localparam logic [1:0] MODE_HOLD   = 2'b10;

  typedef enum logic [1:0] {
    StManual = 2'b00,
    StScan   = 2'b01,
    StHold   = 2'b10
  } state_e;

  localparam int unsigned CH_SYSCALL  = 0;
  localparam int unsigned CH_PC       = 1;
  localparam int unsigned CH_CYCLES   = 2;
  localparam int unsigned CH_JUMP     = 3;
  localparam int unsigned CH_BR_TAKEN = 4;
  localparam int unsigned CH_BRANCH   = 5;
  localparam int unsigned CH_MDATA    = 6;
  localparam int unsigned CH_LOADUSE  = 7;

  // Mode 2'b11 is not a distinct mode; it falls back to manual selection.
  function automatic state_e mode_to_state(input logic [1:0] mode);
    case (mode)
      MODE_SCAN: return StScan;
      MODE_HOLD: return StHold;
      default:   return StManual;
    endcase
  endfunction

endpackage

// File: rtl/dbg_scan_timer.sv
// Auto-scan timer: dwell counter, channel index advance and wrap pulse.
// idx_next is the index that will be current after the coming edge, so the top can
// register the matching channel word in the same cycle.
module dbg_scan_timer
  import dbg_view_pkg::*;
#(
  parameter int unsigned NUM_CH  = 8,
  parameter int unsigned SEL_W   = 4,
  parameter int unsigned DWELL_W = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               run,
  input  logic [SEL_W-1:0]   load_idx,
  input  logic [DWELL_W-1:0] dwell,
  output logic [SEL_W-1:0]   idx_next,
  output logic               wrap
);

  localparam logic [SEL_W-1:0] LastIdx = SEL_W'(NUM_CH - 1);

  logic [SEL_W-1:0]   idx_q, idx_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d, dwell_m1;
  logic               wrap_q, wrap_d;

  // A dwell of 0 behaves like 1; >= lets a shortened dwell take effect immediately.
  assign dwell_m1 = (dwell == '0) ? '0 : dwell - DWELL_W'(1);

  // Next-state: load on scan entry, count/advance while scanning, otherwise stand still.
  always_comb begin
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (load) begin
      idx_d = load_idx;
      cnt_d = '0;
    end else if (run) begin
      if (cnt_q >= dwell_m1) begin
        cnt_d = '0;
        if (idx_q == LastIdx) begin
          idx_d  = '0;
          wrap_d = 1'b1;
        end else begin
          idx_d = idx_q + SEL_W'(1);
        end
      end else begin
        cnt_d = cnt_q + DWELL_W'(1);
      end
    end
  end

  // Timer state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q  <= '0;
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  assign idx_next = idx_d;
  assign wrap     = wrap_q;

endmodule

// File: rtl/dbg_view_sel.sv
// Registered debug-display selector: manual, auto-scan and hold views of the CPU
// statistic channels. Define DBG_VIEW_SNAPSHOT_EN to add the snap input and a shadow
// bank so the display reads a coherent snapshot of all counters.
module dbg_view_sel
  import dbg_view_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NUM_CH  = 8,
  parameter int unsigned SEL_W   = 4,
  parameter int unsigned DWELL_W = 24
) (
  input  logic                     clk,
  input  logic                     reset,
`ifdef DBG_VIEW_SNAPSHOT_EN
  input  logic                     snap,
`endif
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic [SEL_W-1:0]         sel,
  input  logic [1:0]               mode,
  input  logic [DWELL_W-1:0]       dwell,
  output logic [DATA_W-1:0]        view_out,
  output logic [SEL_W-1:0]         view_ch,
  output logic                     scan_wrap
);

  localparam logic [SEL_W-1:0] LastIdx = SEL_W'(NUM_CH - 1);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   view_out_q, view_out_d, man_word, scan_word;
  logic [SEL_W-1:0]    view_ch_q, view_ch_d, idx_next, load_idx;
  logic                scan_load, scan_run, wrap;
  logic [NUM_CH*DATA_W-1:0] src;

`ifdef DBG_VIEW_SNAPSHOT_EN
  logic [NUM_CH*DATA_W-1:0] shadow_q;

  // Shadow bank captures every channel at once; keeps capturing even during hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q <= '0;
    end else if (snap) begin
      shadow_q <= ch_data;
    end
  end

  assign src = shadow_q;
`else
  assign src = ch_data;
`endif

  assign state_d   = mode_to_state(mode);
  assign scan_load = (state_d == StScan) && (state_q != StScan);
  assign scan_run  = (state_d == StScan) && (state_q == StScan);
  assign load_idx  = (sel > LastIdx) ? LastIdx : sel;

  dbg_scan_timer #(
    .NUM_CH  (NUM_CH),
    .SEL_W   (SEL_W),
    .DWELL_W (DWELL_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (scan_load),
    .run      (scan_run),
    .load_idx (load_idx),
    .dwell    (dwell),
    .idx_next (idx_next),
    .wrap     (wrap)
  );

  // Channel muxes; an out-of-range manual select yields zero.
  always_comb begin
    man_word  = '0;
    scan_word = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (sel == SEL_W'(k)) man_word = src[k*DATA_W +: DATA_W];
      if (idx_next == SEL_W'(k)) scan_word = src[k*DATA_W +: DATA_W];
    end
  end

  // Output next-state, chosen by the state being entered this edge.
  always_comb begin
    view_out_d = view_out_q;
    view_ch_d  = view_ch_q;
    unique case (state_d)
      StManual: begin
        view_out_d = man_word;
        view_ch_d  = sel;
      end
      StScan: begin
        view_out_d = scan_word;
        view_ch_d  = idx_next;
      end
      default: ;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StManual;
      view_out_q <= '0;
      view_ch_q  <= '0;
    end else begin
      state_q    <= state_d;
      view_out_q <= view_out_d;
      view_ch_q  <= view_ch_d;
    end
  end

  assign view_out  = view_out_q;
  assign view_ch   = view_ch_q;
  assign scan_wrap = wrap;

endmodule

// File: tb/tb_dbg_view_sel.sv
// Scoreboard bench for dbg_view_sel (default parameters). The driver pushes the
// expected outputs for each upcoming edge; a monitor pops and compares after it.
module tb_dbg_view_sel;
  import dbg_view_pkg::*;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned NUM_CH = 8;
`ifdef DBG_VIEW_SNAPSHOT_EN
  localparam int SnapLat = 1;
`else
  localparam int SnapLat = 0;
`endif

  typedef struct {
    string       name;
    bit          c_out;
    bit          c_ch;
    bit          c_wrap;
    logic [31:0] out;
    logic [3:0]  ch;
    logic        wrap;
  } exp_t;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic [3:0]               sel;
  logic [1:0]               mode;
  logic [23:0]              dwell;
  logic [31:0]              view_out;
  logic [3:0]               view_ch;
  logic                     scan_wrap;
`ifdef DBG_VIEW_SNAPSHOT_EN
  logic                     snap;
`endif

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  dbg_view_sel dut (
    .clk       (clk),
    .reset     (reset),
`ifdef DBG_VIEW_SNAPSHOT_EN
    .snap      (snap),
`endif
    .ch_data   (ch_data),
    .sel       (sel),
    .mode      (mode),
    .dwell     (dwell),
    .view_out  (view_out),
    .view_ch   (view_ch),
    .scan_wrap (scan_wrap)
  );

  always #5 clk = ~clk;

  // Monitor: one expectation per edge, compared 1 time unit after it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (e.c_out) begin
          n_checks++;
          if (view_out !== e.out) begin
            n_fail++;
            $display("FAIL %s view_out: got %h expected %h", e.name, view_out, e.out);
          end
        end
        if (e.c_ch) begin
          n_checks++;
          if (view_ch !== e.ch) begin
            n_fail++;
            $display("FAIL %s view_ch: got %0d expected %0d", e.name, view_ch, e.ch);
          end
        end
        if (e.c_wrap) begin
          n_checks++;
          if (scan_wrap !== e.wrap) begin
            n_fail++;
            $display("FAIL %s scan_wrap: got %b expected %b", e.name, scan_wrap, e.wrap);
          end
        end
      end
    end
  end

  task automatic step(input string nm, input bit co, input bit cc, input bit cw,
                      input logic [31:0] eo, input logic [3:0] ec, input logic ew);
    exp_t e;
    e.name = nm; e.c_out = co; e.c_ch = cc; e.c_wrap = cw;
    e.out = eo; e.ch = ec; e.wrap = ew;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] eo, input logic [3:0] ec,
                     input logic ew);
    step(nm, 1'b1, 1'b1, 1'b1, eo, ec, ew);
  endtask

  // Extra unchecked edges the snapshot build needs before the shadow bank is filled.
  task automatic settle();
    for (int i = 0; i < SnapLat; i++) step("settle", 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic set_ch(input int k, input logic [31:0] v);
    ch_data[k*DATA_W +: DATA_W] = v;
  endtask

  initial begin
    int seq_a[12] = '{6, 6, 6, 6, 7, 7, 7, 7, 0, 0, 0, 0};
    int seq_b[10] = '{1, 2, 3, 4, 5, 6, 7, 0, 1, 2};
    int seq_c[11] = '{5, 5, 6, 6, 7, 7, 0, 0, 1, 1, 2};
    logic [31:0] eo;

    reset = 1'b1; mode = MODE_MANUAL; sel = 4'd3; dwell = 24'd4;
`ifdef DBG_VIEW_SNAPSHOT_EN
    snap = 1'b1;
`endif
    for (int k = 0; k < int'(NUM_CH); k++) set_ch(k, 32'h1000_0000 + k);

    // Reset state, including while sel already selects a valid channel.
    chk("reset0", 32'h0, 4'd0, 1'b0);
    chk("reset1", 32'h0, 4'd0, 1'b0);
    reset = 1'b0;
    settle();

    // Manual selection.
    chk("man_sel3", 32'h1000_0003, 4'd3, 1'b0);
    sel = 4'd9;
    chk("man_sel9", 32'h0, 4'd9, 1'b0);
    sel = 4'(CH_LOADUSE);
    chk("man_sel7", 32'h1000_0007, 4'd7, 1'b0);
    set_ch(7, 32'h5555_AAAA);
    step("man_live_a", 1'b0, 1'b1, 1'b1, 32'h0, 4'd7, 1'b0);
    chk("man_live_b", 32'h5555_AAAA, 4'd7, 1'b0);
    set_ch(7, 32'h1000_0007);
    mode = 2'b11; sel = 4'd2;
    chk("mode11_manual", 32'h1000_0002, 4'd2, 1'b0);
    settle();

    // Auto-scan from sel=6, dwell=4; sel changes mid-scan are ignored.
    mode = MODE_SCAN; sel = 4'd6; dwell = 24'd4;
    for (int i = 0; i < 12; i++) begin
      chk("scan_d4", 32'h1000_0000 + seq_a[i], 4'(seq_a[i]), (i == 8));
      if (i == 0) sel = 4'd2;
    end

    // Dwell drops to 0 with the counter already past it: advance every cycle.
    dwell = 24'd0;
    for (int i = 0; i < 10; i++)
      chk("scan_d0", 32'h1000_0000 + seq_b[i], 4'(seq_b[i]), (i == 7));

    // Hold at channel 2 while channel 2 and sel change.
    mode = MODE_HOLD; sel = 4'd0;
    set_ch(2, 32'hDEAD_BEEF);
    for (int i = 0; i < 20; i++) chk("hold", 32'h1000_0002, 4'd2, 1'b0);

    // Leave hold into scan: index reloads from sel, dwell=2.
    mode = MODE_SCAN; sel = 4'd5; dwell = 24'd2;
    for (int i = 0; i < 11; i++) begin
      eo = (seq_c[i] == 2) ? 32'hDEAD_BEEF : 32'h1000_0000 + seq_c[i];
      chk("scan_d2", eo, 4'(seq_c[i]), (i == 6));
    end

    // Out-of-range sel: manual shows 0, scan entry clamps to the last channel.
    mode = MODE_MANUAL; sel = 4'd12;
    chk("man_sel12", 32'h0, 4'd12, 1'b0);
    mode = MODE_SCAN; dwell = 24'd1;
    chk("scan_clamp", 32'h1000_0007, 4'd7, 1'b0);
    chk("scan_clamp_wrap", 32'h1000_0000, 4'd0, 1'b1);
    chk("scan_clamp_next", 32'h1000_0001, 4'd1, 1'b0);

    // Reset mid-scan, then manual (mode 11), then scan re-entry from sel.
    reset = 1'b1;
    chk("reset_mid", 32'h0, 4'd0, 1'b0);
    reset = 1'b0; mode = 2'b11; sel = 4'd1;
    settle();
    chk("post_reset_man", 32'h1000_0001, 4'd1, 1'b0);
    mode = MODE_SCAN; sel = 4'(CH_BR_TAKEN); dwell = 24'd4;
    chk("reentry", 32'h1000_0004, 4'd4, 1'b0);
    mode = MODE_HOLD;
    chk("hold_scan", 32'h1000_0004, 4'd4, 1'b0);

`ifdef DBG_VIEW_SNAPSHOT_EN
    // Snapshot: later channel changes stay invisible until the next snap.
    mode = MODE_MANUAL; sel = 4'd1; snap = 1'b1;
    set_ch(1, 32'h0000_0040);
    step("snap_cap", 1'b0, 1'b1, 1'b0, 32'h0, 4'd1, 1'b0);
    snap = 1'b0;
    set_ch(1, 32'h0000_0099);
    for (int i = 0; i < 3; i++) chk("snap_hold", 32'h0000_0040, 4'd1, 1'b0);
    snap = 1'b1;
    chk("snap_again", 32'h0000_0040, 4'd1, 1'b0);
    snap = 1'b0;
    chk("snap_new", 32'h0000_0099, 4'd1, 1'b0);
`endif

    @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
